// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, fetches over imem req/ack, holds each word for decode.
// Optional feature macro MISALIGN_TRAP_EN: misaligned jr targets trap into a sticky ERROR state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: imem_req rises on entry to FETCH and stays high with imem_addr stable
  // until a single-cycle imem_ack; the word is captured on that edge and the request
  // drops. imem_ack in any other state is ignored. Decode consumes the held word on a
  // HOLD cycle with stall=0, which is also the only cycle redirect inputs are sampled.

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_req;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_disp;
  logic [31:0] w_jr_dest;
  logic [31:0] w_next_pc;
  logic        w_retire;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_disp  = imm_ext << 2;
  assign w_retire   = (r_state == S_HOLD) && !stall;

`ifdef MISALIGN_TRAP_EN
  logic r_fetch_err;
  logic w_jr_trap;
  assign w_jr_dest  = jr_target;
  assign w_jr_trap  = jr && (jr_target[1:0] != 2'b00);
  assign fetch_err  = r_fetch_err;
`else
  // Without the trap, word alignment is enforced by dropping the low target bits.
  assign w_jr_dest  = jr_target & 32'hFFFF_FFFC;
  assign fetch_err  = 1'b0;
`endif

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr)
      w_next_pc = w_jr_dest;
    else if (jump)
      w_next_pc = {w_pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      w_next_pc = w_pc_plus4 + w_br_disp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0;
      r_valid     <= 1'b0;
      r_req       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_fetch_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_retire) begin
`ifdef MISALIGN_TRAP_EN
            if (w_jr_trap) begin
              r_pc        <= jr_target;
              r_fetch_err <= 1'b1;
              r_valid     <= 1'b0;
              r_req       <= 1'b0;
              r_state     <= S_ERROR;
            end else begin
              r_pc    <= w_next_pc;
              r_valid <= 1'b0;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
`else
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
`endif
          end
        end
`ifdef MISALIGN_TRAP_EN
        S_ERROR: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign o_dbg_state = r_state;

endmodule
